// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM read master that fetches the system-ID word
// (address 0) and build timestamp (address 1) after reset or on request,
// compares both against expected values and reports pass/fail/timeout.
module sysid_reader #(
   parameter logic [31:0] EXPECTED_ID    = 32'd0,
   parameter logic [31:0] EXPECTED_TS    = 32'd1617477851,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   output logic [31:0] id_word,
   output logic [31:0] ts_word,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ID_REQ  = 3'd1,
      ID_WAIT = 3'd2,
      TS_REQ  = 3'd3,
      TS_WAIT = 3'd4,
      FINISH  = 3'd5
   } state_t;

   // Per-read cycle budget, counted from the first cycle the request is driven.
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic        auto_start_q, auto_start_d;
   logic        avm_read_q, avm_read_d;
   logic        avm_address_q, avm_address_d;
   logic [31:0] id_word_q, id_word_d;
   logic [31:0] ts_word_q, ts_word_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;

   logic [15:0] timer_inc;
   logic        accept;
   logic        got_data;
   logic        in_read;
   logic        ts_phase;

   // Next-state and next-output computation for the whole read sequence.
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      auto_start_d  = 1'b0;
      avm_read_d    = avm_read_q;
      avm_address_d = avm_address_q;
      id_word_d     = id_word_q;
      ts_word_d     = ts_word_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      id_ok_d       = id_ok_q;
      ts_ok_d       = ts_ok_q;
      timeout_d     = timeout_q;

      timer_inc = timer_q + 16'd1;
      accept    = avm_read_q && !avm_waitrequest;
      got_data  = 1'b0;
      in_read   = (state_q == ID_REQ) || (state_q == ID_WAIT) ||
                  (state_q == TS_REQ) || (state_q == TS_WAIT);
      ts_phase  = (state_q == TS_REQ) || (state_q == TS_WAIT);

      case (state_q)
         IDLE: begin
            // The auto-start flag is only ever set in the first post-reset cycle.
            if (start || auto_start_q) begin
               state_d       = ID_REQ;
               busy_d        = 1'b1;
               id_ok_d       = 1'b0;
               ts_ok_d       = 1'b0;
               timeout_d     = 1'b0;
               timer_d       = 16'd0;
               avm_read_d    = 1'b1;
               avm_address_d = 1'b0;
            end
         end
         ID_REQ, TS_REQ: begin
            timer_d = timer_inc;
            if (accept) begin
               avm_read_d = 1'b0;
               // A zero-latency slave returns data in the acceptance cycle.
               if (avm_readdatavalid) begin
                  got_data = 1'b1;
               end else begin
                  state_d = (state_q == ID_REQ) ? ID_WAIT : TS_WAIT;
               end
            end
         end
         ID_WAIT, TS_WAIT: begin
            timer_d = timer_inc;
            if (avm_readdatavalid) begin
               got_data = 1'b1;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (got_data) begin
         if (!ts_phase) begin
            id_word_d     = avm_readdata;
            state_d       = TS_REQ;
            timer_d       = 16'd0;
            avm_read_d    = 1'b1;
            avm_address_d = 1'b1;
         end else begin
            ts_word_d = avm_readdata;
            state_d   = FINISH;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            id_ok_d   = (id_word_q == EXPECTED_ID);
            ts_ok_d   = (avm_readdata == EXPECTED_TS);
         end
      end else if (in_read && (timer_inc >= TIMEOUT_LIMIT)) begin
         // Data arriving in the final allowed cycle still wins over timeout.
         timeout_d  = 1'b1;
         avm_read_d = 1'b0;
         state_d    = FINISH;
         busy_d     = 1'b0;
         done_d     = 1'b1;
         id_ok_d    = 1'b0;
         ts_ok_d    = 1'b0;
      end
   end

   // State and registered outputs; synchronous reset returns everything to idle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         timer_q       <= 16'd0;
         auto_start_q  <= AUTO_START;
         avm_read_q    <= 1'b0;
         avm_address_q <= 1'b0;
         id_word_q     <= 32'd0;
         ts_word_q     <= 32'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         auto_start_q  <= auto_start_d;
         avm_read_q    <= avm_read_d;
         avm_address_q <= avm_address_d;
         id_word_q     <= id_word_d;
         ts_word_q     <= ts_word_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         ts_ok_q       <= ts_ok_d;
         timeout_q     <= timeout_d;
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign id_word     = id_word_q;
   assign ts_word     = ts_word_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;

endmodule
